// File: rtl/nec_bus_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : nec_bus_ctrl_if
//  Description : NEC V30 pin bundle plus backing memory/IO request port.
//  Revision    : 1.0  initial release
// ============================================================================
interface nec_bus_ctrl_if;
    logic        nec_clk;
    logic [19:0] nec_ad_in;
    logic [15:0] nec_ad_out;
    logic        nec_ad_oe;
    logic        nec_ad_dir;
    logic        nec_astb;
    logic        nec_rdn;
    logic        nec_wrn;
    logic        nec_ion;
    logic        nec_uben;
    logic        nec_ready;
    logic        mem_req;
    logic        mem_wr;
    logic        mem_io;
    logic [19:0] mem_addr;
    logic [1:0]  mem_be;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] cycle_count;
    logic        protocol_err;
    logic        timeout_err;

    modport slave (
        input  nec_ad_in, nec_astb, nec_rdn, nec_wrn, nec_ion, nec_uben,
        input  mem_rdata, mem_ack,
        output nec_clk, nec_ad_out, nec_ad_oe, nec_ad_dir, nec_ready,
        output mem_req, mem_wr, mem_io, mem_addr, mem_be, mem_wdata,
        output cycle_count, protocol_err, timeout_err
    );

    modport master (
        output nec_ad_in, nec_astb, nec_rdn, nec_wrn, nec_ion, nec_uben,
        output mem_rdata, mem_ack,
        input  nec_clk, nec_ad_out, nec_ad_oe, nec_ad_dir, nec_ready,
        input  mem_req, mem_wr, mem_io, mem_addr, mem_be, mem_wdata,
        input  cycle_count, protocol_err, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/nec_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : nec_bus_ctrl
//  Description : NEC V30 bus-cycle slave; forwards each access to a memory
//                port. Define NEC_BUS_TIMEOUT_EN to force completion when
//                mem_ack never arrives.
//  Revision    : 1.0  initial release
// ============================================================================
module nec_bus_ctrl #(
    parameter int unsigned WAIT_STATES    = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  wire           clk_sys,
    input  wire           reset,
    nec_bus_ctrl_if.slave bus
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_REQ  = 3'd2,
        S_HOLD = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          state_q;
    logic [1:0]      div_q;
    logic [19:0]     ad_s1_q, ad_s2_q;
    logic [4:0]      ctl_s1_q, ctl_s2_q;
    logic            astb_prev_q;
    logic [3:0]      wait_q;
    logic            armed_q;
    logic [TO_W-1:0] to_cnt_q;

    logic [15:0]     ad_out_q;
    logic            oe_q, dir_q, ready_q;
    logic            req_q, wr_q, io_q;
    logic [19:0]     addr_q;
    logic [1:0]      be_q;
    logic [15:0]     wdata_q;
    logic [31:0]     count_q;
    logic            perr_q, terr_q;

    logic w_astb_s, w_rdn_s, w_wrn_s, w_ion_s, w_uben_s;
    logic w_astb_fall, w_tick;

    assign {w_astb_s, w_rdn_s, w_wrn_s, w_ion_s, w_uben_s} = ctl_s2_q;
    assign w_astb_fall = astb_prev_q & ~w_astb_s;
    assign w_tick      = (div_q == 2'd3);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= S_IDLE;
            div_q       <= 2'd0;
            ad_s1_q     <= '0;
            ad_s2_q     <= '0;
            ctl_s1_q    <= '0;
            ctl_s2_q    <= '0;
            astb_prev_q <= 1'b0;
            wait_q      <= 4'd0;
            armed_q     <= 1'b0;
            to_cnt_q    <= '0;
            ad_out_q    <= 16'd0;
            oe_q        <= 1'b0;
            dir_q       <= 1'b0;
            ready_q     <= 1'b0;
            req_q       <= 1'b0;
            wr_q        <= 1'b0;
            io_q        <= 1'b0;
            addr_q      <= 20'd0;
            be_q        <= 2'b00;
            wdata_q     <= 16'd0;
            count_q     <= 32'd0;
            perr_q      <= 1'b0;
            terr_q      <= 1'b0;
        end else begin
            div_q       <= div_q + 2'd1;
            ad_s1_q     <= bus.nec_ad_in;
            ad_s2_q     <= ad_s1_q;
            ctl_s1_q    <= {bus.nec_astb, bus.nec_rdn, bus.nec_wrn, bus.nec_ion, bus.nec_uben};
            ctl_s2_q    <= ctl_s1_q;
            astb_prev_q <= w_astb_s;

            if (w_astb_fall && (state_q != S_IDLE)) begin
                perr_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (w_astb_fall) begin
                        addr_q  <= ad_s2_q;
                        io_q    <= ~w_ion_s;
                        be_q    <= {~w_uben_s, ~ad_s2_q[0]};
                        state_q <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (!w_rdn_s && !w_wrn_s) begin
                        perr_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (!w_rdn_s) begin
                        wr_q     <= 1'b0;
                        req_q    <= 1'b1;
                        to_cnt_q <= '0;
                        state_q  <= S_REQ;
                    end else if (!w_wrn_s) begin
                        wr_q     <= 1'b1;
                        wdata_q  <= ad_s2_q[15:0];
                        req_q    <= 1'b1;
                        to_cnt_q <= '0;
                        state_q  <= S_REQ;
                    end
                end
                S_REQ: begin
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                    if (bus.mem_ack) begin
                        req_q <= 1'b0;
                        if (!wr_q) begin
                            ad_out_q <= bus.mem_rdata;
                            oe_q     <= 1'b1;
                            dir_q    <= 1'b1;
                        end
                        wait_q  <= 4'(WAIT_STATES);
                        armed_q <= 1'b0;
                        state_q <= S_HOLD;
                    end
`ifdef NEC_BUS_TIMEOUT_EN
                    else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        req_q  <= 1'b0;
                        terr_q <= 1'b1;
                        if (!wr_q) begin
                            ad_out_q <= 16'hFFFF;
                            oe_q     <= 1'b1;
                            dir_q    <= 1'b1;
                        end
                        wait_q  <= 4'(WAIT_STATES);
                        armed_q <= 1'b0;
                        state_q <= S_HOLD;
                    end
`endif
                end
                S_HOLD: begin
                    // The first divider wrap after entry closes a partial
                    // period, so only wraps after it count as full wait states.
                    if (wait_q == 4'd0) begin
                        ready_q <= 1'b1;
                        state_q <= S_DONE;
                    end else if (w_tick) begin
                        armed_q <= 1'b1;
                        if (armed_q) begin
                            wait_q <= wait_q - 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (w_rdn_s && w_wrn_s) begin
                        ready_q <= 1'b0;
                        oe_q    <= 1'b0;
                        dir_q   <= 1'b0;
                        count_q <= count_q + 32'd1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.nec_clk      = div_q[1];
    assign bus.nec_ad_out   = ad_out_q;
    assign bus.nec_ad_oe    = oe_q;
    assign bus.nec_ad_dir   = dir_q;
    assign bus.nec_ready    = ready_q;
    assign bus.mem_req      = req_q;
    assign bus.mem_wr       = wr_q;
    assign bus.mem_io       = io_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_be       = be_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.cycle_count  = count_q;
    assign bus.protocol_err = perr_q;
    assign bus.timeout_err  = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_nec_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nec_bus_ctrl
//  Description : Scoreboard bench for nec_bus_ctrl (WAIT_STATES 1 and 0).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nec_bus_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, sel, mon_en;
    logic [19:0] ad_in;
    logic        astb, rdn, wrn, ion, uben, ack;
    logic [15:0] rdata;

    nec_bus_ctrl_if ifa ();
    nec_bus_ctrl_if ifb ();

    assign ifa.nec_ad_in = ad_in;  assign ifb.nec_ad_in = ad_in;
    assign ifa.nec_astb  = astb;   assign ifb.nec_astb  = astb;
    assign ifa.nec_rdn   = rdn;    assign ifb.nec_rdn   = rdn;
    assign ifa.nec_wrn   = wrn;    assign ifb.nec_wrn   = wrn;
    assign ifa.nec_ion   = ion;    assign ifb.nec_ion   = ion;
    assign ifa.nec_uben  = uben;   assign ifb.nec_uben  = uben;
    assign ifa.mem_rdata = rdata;  assign ifb.mem_rdata = rdata;
    assign ifa.mem_ack   = ack;    assign ifb.mem_ack   = ack;

    nec_bus_ctrl #(.WAIT_STATES(1), .TIMEOUT_CYCLES(16)) u_dut_a (
        .clk_sys (clk), .reset (rst_a), .bus (ifa));
    nec_bus_ctrl #(.WAIT_STATES(0)) u_dut_b (
        .clk_sys (clk), .reset (rst_b), .bus (ifb));

    logic        w_nclk, w_oe, w_dir, w_rdy, w_req, w_wr, w_io, w_perr, w_terr;
    logic [15:0] w_adout, w_wdata;
    logic [19:0] w_addr;
    logic [1:0]  w_be;
    logic [31:0] w_cnt;
    assign w_nclk  = sel ? ifb.nec_clk      : ifa.nec_clk;
    assign w_adout = sel ? ifb.nec_ad_out   : ifa.nec_ad_out;
    assign w_oe    = sel ? ifb.nec_ad_oe    : ifa.nec_ad_oe;
    assign w_dir   = sel ? ifb.nec_ad_dir   : ifa.nec_ad_dir;
    assign w_rdy   = sel ? ifb.nec_ready    : ifa.nec_ready;
    assign w_req   = sel ? ifb.mem_req      : ifa.mem_req;
    assign w_wr    = sel ? ifb.mem_wr       : ifa.mem_wr;
    assign w_io    = sel ? ifb.mem_io       : ifa.mem_io;
    assign w_addr  = sel ? ifb.mem_addr     : ifa.mem_addr;
    assign w_be    = sel ? ifb.mem_be       : ifa.mem_be;
    assign w_wdata = sel ? ifb.mem_wdata    : ifa.mem_wdata;
    assign w_cnt   = sel ? ifb.cycle_count  : ifa.cycle_count;
    assign w_perr  = sel ? ifb.protocol_err : ifa.protocol_err;
    assign w_terr  = sel ? ifb.timeout_err  : ifa.timeout_err;

    typedef struct { logic [19:0] addr; logic wr; logic io; logic [1:0] be; logic [15:0] wdata; } req_t;
    typedef struct { logic rd; logic [15:0] data; logic timed; int gmin; int gmax; } cpl_t;
    typedef struct { int dly; logic [15:0] data; int mode; } rsp_t;

    req_t exp_req_q[$];
    cpl_t exp_cpl_q[$];
    rsp_t rsp_q[$];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int ack_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // mode 0: normal ack, 1: never acked and no completion, 2: never acked then late ack, data FFFF
    task automatic expect_cycle(input logic [19:0] a, input logic wr, input logic io,
                                input logic [1:0] be, input logic [15:0] wd,
                                input logic [15:0] rd_data, input int dly, input int mode,
                                input int gmin, input int gmax);
        req_t r;
        cpl_t c;
        rsp_t s;
        r.addr = a; r.wr = wr; r.io = io; r.be = be; r.wdata = wd;
        exp_req_q.push_back(r);
        s.dly = dly; s.data = rd_data; s.mode = mode;
        rsp_q.push_back(s);
        if (mode != 1) begin
            c.rd    = ~wr;
            c.data  = (mode == 2) ? 16'hFFFF : rd_data;
            c.timed = (mode == 2);
            c.gmin  = gmin;
            c.gmax  = gmax;
            exp_cpl_q.push_back(c);
        end
    endtask

    task automatic cpu_addr(input logic [19:0] a, input logic io_n, input logic ube_n);
        @(negedge clk);
        astb = 1'b1; ad_in = a; ion = io_n; uben = ube_n;
        repeat (2) @(negedge clk);
        astb = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cpu_strobe(input logic is_wr, input logic [15:0] wd);
        if (is_wr) begin
            ad_in[15:0] = wd;
            wrn = 1'b0;
        end else begin
            rdn = 1'b0;
        end
    endtask

    task automatic cpu_finish(input string name);
        int g;
        g = 0;
        while (!w_rdy && g < 300) begin @(negedge clk); g++; end
        chk({name, "_ready_seen"}, w_rdy, 1'b1);
        repeat (2) @(negedge clk);
        rdn = 1'b1; wrn = 1'b1;
        g = 0;
        while (w_rdy && g < 50) begin @(negedge clk); g++; end
        chk({name, "_ready_release"}, w_rdy, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (ack && w_req) ack_cyc = cyc;
        end
    end

    // Monitor: pops expectations whenever the DUT raises mem_req or READY.
    initial begin
        logic prev_req, prev_rdy;
        req_t r;
        cpl_t c;
        int   gap;
        prev_req = 1'b0; prev_rdy = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en) begin
                if (w_req && !prev_req) begin
                    if (exp_req_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_req: got request addr %0h required no request", w_addr);
                    end else begin
                        r = exp_req_q.pop_front();
                        chk("req_addr", w_addr, r.addr);
                        chk("req_wr", w_wr, r.wr);
                        chk("req_io", w_io, r.io);
                        chk("req_be", w_be, r.be);
                        if (r.wr) chk("req_wdata", w_wdata, r.wdata);
                    end
                end
                if (w_rdy && !prev_rdy) begin
                    if (exp_cpl_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_ready: got READY=1 required 0");
                    end else begin
                        c = exp_cpl_q.pop_front();
                        chk("cpl_oe", w_oe, c.rd);
                        chk("cpl_dir", w_dir, c.rd);
                        if (c.rd) chk("cpl_ad_out", w_adout, c.data);
                        if (!c.timed) begin
                            gap = cyc - ack_cyc;
                            n_chk++;
                            if (gap < c.gmin || gap > c.gmax) begin
                                n_fail++;
                                $display("FAIL ack_to_ready: got %0d cycles required %0d..%0d", gap, c.gmin, c.gmax);
                            end
                        end
                    end
                end
                if (!w_rdy && prev_rdy) chk("oe_after_release", w_oe, 1'b0);
                if (w_req) begin
                    chk("ready_low_in_req", w_rdy, 1'b0);
                    chk("oe_low_in_req", w_oe, 1'b0);
                end
                if (w_wr) chk("oe_low_on_write", w_oe, 1'b0);
            end
            prev_req = w_req;
            prev_rdy = w_rdy;
        end
    end

    // Memory responder
    initial begin
        rsp_t s;
        int   g;
        ack = 1'b0; rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (mon_en && w_req && rsp_q.size() != 0) begin
                s = rsp_q.pop_front();
                if (s.mode != 0) begin
                    g = 0;
                    while (w_req && g < 2000) begin @(negedge clk); g++; end
                    if (s.mode == 2) begin
                        ack = 1'b1; rdata = 16'h1111;
                        @(negedge clk);
                        ack = 1'b0;
                    end
                end else begin
                    repeat (s.dly - 1) @(negedge clk);
                    ack = 1'b1; rdata = s.data;
                    @(negedge clk);
                    ack = 1'b0; rdata = 16'h0000;
                end
            end
        end
    end

    initial begin
        int g, n;
        rst_a = 1'b1; rst_b = 1'b1; sel = 1'b0; mon_en = 1'b0;
        ad_in = 20'h0; astb = 1'b1; rdn = 1'b1; wrn = 1'b1; ion = 1'b1; uben = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_nec_clk", w_nclk, 1'b0);
        chk("rst_ready", w_rdy, 1'b0);
        chk("rst_oe", w_oe, 1'b0);
        chk("rst_req", w_req, 1'b0);
        chk("rst_addr", w_addr, 20'h0);
        chk("rst_count", w_cnt, 32'h0);

        rst_a = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("nec_clk_div", w_nclk, ((i % 4) >= 2) ? 1 : 0);
        end
        mon_en = 1'b1;

        // memory read, even address, both bytes
        expect_cycle(20'h12344, 1'b0, 1'b0, 2'b11, 16'h0, 16'hBEEF, 5, 0, 4, 12);
        cpu_addr(20'h12344, 1'b1, 1'b0); cpu_strobe(1'b0, 16'h0); cpu_finish("rd1");
        chk("count_after_rd1", w_cnt, 32'd1);

        // IO write, odd address with UBEn high: no byte lanes enabled
        expect_cycle(20'h00081, 1'b1, 1'b1, 2'b00, 16'h5A5A, 16'h0, 3, 0, 4, 12);
        cpu_addr(20'h00081, 1'b0, 1'b1); cpu_strobe(1'b1, 16'h5A5A); cpu_finish("iowr");
        chk("count_after_iowr", w_cnt, 32'd2);
        chk("perr_clean", w_perr, 1'b0);

        // RDn and WRn together
        cpu_addr(20'h00200, 1'b1, 1'b0);
        rdn = 1'b0; wrn = 1'b0;
        repeat (8) @(negedge clk);
        chk("perr_set", w_perr, 1'b1);
        chk("perr_no_req", w_req, 1'b0);
        rdn = 1'b1; wrn = 1'b1;
        repeat (3) @(negedge clk);
        expect_cycle(20'h00300, 1'b0, 1'b0, 2'b11, 16'h0, 16'h1234, 2, 0, 4, 12);
        cpu_addr(20'h00300, 1'b1, 1'b0); cpu_strobe(1'b0, 16'h0); cpu_finish("rd_after_err");
        chk("count_after_err", w_cnt, 32'd3);
        chk("perr_sticky", w_perr, 1'b1);

        // reset while a request is outstanding
        expect_cycle(20'h0ABCD, 1'b0, 1'b0, 2'b10, 16'h0, 16'h0, 1, 1, 0, 0);
        cpu_addr(20'h0ABCD, 1'b1, 1'b0); cpu_strobe(1'b0, 16'h0);
        g = 0;
        while (!w_req && g < 50) begin @(negedge clk); g++; end
        chk("req_before_reset", w_req, 1'b1);
        rst_a = 1'b1;
        @(negedge clk);
        chk("midrst_req", w_req, 1'b0);
        chk("midrst_addr", w_addr, 20'h0);
        chk("midrst_be", w_be, 2'b00);
        chk("midrst_count", w_cnt, 32'h0);
        chk("midrst_perr", w_perr, 1'b0);
        chk("midrst_nec_clk", w_nclk, 1'b0);
        rdn = 1'b1;
        rst_a = 1'b0;
        repeat (3) @(negedge clk);

`ifdef NEC_BUS_TIMEOUT_EN
        expect_cycle(20'h00400, 1'b0, 1'b0, 2'b11, 16'h0, 16'h0, 1, 2, 0, 0);
        cpu_addr(20'h00400, 1'b1, 1'b0); cpu_strobe(1'b0, 16'h0);
        g = 0;
        while (!w_req && g < 50) begin @(negedge clk); g++; end
        n = 0;
        while (w_req && n < 100) begin @(negedge clk); n++; end
        chk("timeout_req_cycles", n, 32'd16);
        cpu_finish("timeout");
        chk("timeout_err_set", w_terr, 1'b1);
`else
        chk("timeout_err_tied", w_terr, 1'b0);
`endif

        // back-to-back reads on the zero-wait-state instance
        rst_a = 1'b1; sel = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("b_count_start", w_cnt, 32'd0);
        expect_cycle(20'h01000, 1'b0, 1'b0, 2'b11, 16'h0, 16'hC001, 1, 0, 2, 3);
        cpu_addr(20'h01000, 1'b1, 1'b0); cpu_strobe(1'b0, 16'h0); cpu_finish("b2b_0");
        expect_cycle(20'h01003, 1'b0, 1'b0, 2'b10, 16'h0, 16'hD00D, 1, 0, 2, 3);
        cpu_addr(20'h01003, 1'b1, 1'b0); cpu_strobe(1'b0, 16'h0); cpu_finish("b2b_1");
        chk("b_count_end", w_cnt, 32'd2);

        chk("sb_req_drained", exp_req_q.size(), 32'd0);
        chk("sb_cpl_drained", exp_cpl_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
